jtag_tap_multi_dr: RTL and testbench

Parametrised IEEE 1149.1-style TAP controller: the next generation of the team's single-register TAP. It has a real instruction register that selects among BYPASS, IDCODE and `NUM_USER_DR` user data registers. Each register has its own capture and update path, and a serial `TDO` return path. It sits between the external JTAG pins and on-chip debug/config logic, which supplies capture data and consumes update pulses.

---
 rtl/jtag_pkg.sv | 28 ++
 rtl/jtag_tap_fsm.sv | 41 ++++
 rtl/jtag_tap_multi_dr.sv | 121 ++++++++++++
 tb/tb_jtag_tap_multi_dr.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jtag_pkg.sv
// Shared TAP definitions: fixed 4-bit state encodings and instruction opcodes.
package jtag_pkg;

    typedef enum logic [3:0] {
        TEST_RESET = 4'd0,
        TEST_IDLE  = 4'd1,
        DR_SELECT  = 4'd2,
        DR_CAPTURE = 4'd3,
        DR_SHIFT   = 4'd4,
        DR_EXIT1   = 4'd5,
        DR_PAUSE   = 4'd6,
        DR_EXIT2   = 4'd7,
        DR_UPDATE  = 4'd8,
        IR_SELECT  = 4'd9,
        IR_CAPTURE = 4'd10,
        IR_SHIFT   = 4'd11,
        IR_EXIT1   = 4'd12,
        IR_PAUSE   = 4'd13,
        IR_EXIT2   = 4'd14,
        IR_UPDATE  = 4'd15
    } tap_state_t;

    localparam int          OP_IDCODE    = 1;
    localparam int          OP_USER_BASE = 2;
    // All ones; users truncate to their own IR width.
    localparam logic [31:0] OP_BYPASS    = 32'hFFFF_FFFF;

endpackage

// File: rtl/jtag_tap_fsm.sv
// IEEE 1149.1 TAP state machine: state register plus TMS-driven next-state logic.
module jtag_tap_fsm
    import jtag_pkg::*;
(
    input  logic       TCLK,
    input  logic       TRST,
    input  logic       TMS,
    output tap_state_t state
);

    tap_state_t next_state;

    always_ff @(posedge TCLK) begin
        if (TRST) state <= TEST_RESET;
        else      state <= next_state;
    end

    always_comb begin
        next_state = TEST_RESET;
        case (state)
            TEST_RESET: next_state = TMS ? TEST_RESET : TEST_IDLE;
            TEST_IDLE:  next_state = TMS ? DR_SELECT  : TEST_IDLE;
            DR_SELECT:  next_state = TMS ? IR_SELECT  : DR_CAPTURE;
            DR_CAPTURE: next_state = TMS ? DR_EXIT1   : DR_SHIFT;
            DR_SHIFT:   next_state = TMS ? DR_EXIT1   : DR_SHIFT;
            DR_EXIT1:   next_state = TMS ? DR_UPDATE  : DR_PAUSE;
            DR_PAUSE:   next_state = TMS ? DR_EXIT2   : DR_PAUSE;
            DR_EXIT2:   next_state = TMS ? DR_UPDATE  : DR_SHIFT;
            DR_UPDATE:  next_state = TMS ? DR_SELECT  : TEST_IDLE;
            IR_SELECT:  next_state = TMS ? TEST_RESET : IR_CAPTURE;
            IR_CAPTURE: next_state = TMS ? IR_EXIT1   : IR_SHIFT;
            IR_SHIFT:   next_state = TMS ? IR_EXIT1   : IR_SHIFT;
            IR_EXIT1:   next_state = TMS ? IR_UPDATE  : IR_PAUSE;
            IR_PAUSE:   next_state = TMS ? IR_EXIT2   : IR_PAUSE;
            IR_EXIT2:   next_state = TMS ? IR_UPDATE  : IR_SHIFT;
            IR_UPDATE:  next_state = TMS ? DR_SELECT  : TEST_IDLE;
            default:    next_state = TEST_RESET;
        endcase
    end

endmodule

// File: rtl/jtag_tap_multi_dr.sv
// TAP with a real instruction register selecting BYPASS, IDCODE or one of NUM_USER_DR user registers.
// Define JTAG_TAP_IDCODE_EN to implement IDCODE; otherwise opcode 1 is BYPASS and reset selects BYPASS.
module jtag_tap_multi_dr
    import jtag_pkg::*;
#(
    parameter int          IR_WIDTH    = 4,
    parameter int          DR_WIDTH    = 32,
    parameter int          NUM_USER_DR = 2,
    parameter logic [31:0] IDCODE_VAL  = 32'h1000_0001
) (
    input  logic                          TCLK,
    input  logic                          TRST,
    input  logic                          TMS,
    input  logic                          TDI,
    output logic                          TDO,
    output logic                          TDO_EN,
    output logic [IR_WIDTH-1:0]           ir_value,
    input  logic [NUM_USER_DR*DR_WIDTH-1:0] dr_capture_data,
    output logic [DR_WIDTH-1:0]           dr_update_data,
    output logic [NUM_USER_DR-1:0]        dr_update_valid,
    output logic [3:0]                    tap_state
);

`ifdef JTAG_TAP_IDCODE_EN
    localparam bit                  IDCODE_EN  = 1'b1;
    localparam int                  SR_WIDTH   = (DR_WIDTH > 32) ? DR_WIDTH : 32;
    localparam int                  IDCODE_MSB = 31;
    localparam logic [IR_WIDTH-1:0] IR_RESET   = IR_WIDTH'(OP_IDCODE);
`else
    localparam bit                  IDCODE_EN  = 1'b0;
    localparam int                  SR_WIDTH   = DR_WIDTH;
    localparam int                  IDCODE_MSB = SR_WIDTH - 1;
    localparam logic [IR_WIDTH-1:0] IR_RESET   = IR_WIDTH'(OP_BYPASS);
`endif

    tap_state_t                 state;
    logic [SR_WIDTH-1:0]        dr_sr;
    logic [SR_WIDTH-1:0]        dr_sr_next;
    logic [IR_WIDTH-1:0]        ir_sr;
    logic [IR_WIDTH-1:0]        ir_reg;
    logic                       sel_idcode;
    logic                       sel_user;
    logic [NUM_USER_DR-1:0]     user_onehot;
    logic [DR_WIDTH-1:0]        user_capture;

    jtag_tap_fsm u_fsm (
        .TCLK  (TCLK),
        .TRST  (TRST),
        .TMS   (TMS),
        .state (state)
    );

    // TEST_RESET forces the reset instruction immediately, not one cycle after entry.
    assign ir_value  = (state == TEST_RESET) ? IR_RESET : ir_reg;
    assign tap_state = state;
    assign TDO_EN    = (state == DR_SHIFT) || (state == IR_SHIFT);

    always_comb begin
        sel_idcode   = IDCODE_EN && (ir_value == IR_WIDTH'(OP_IDCODE));
        user_onehot  = '0;
        user_capture = '0;
        for (int k = 0; k < NUM_USER_DR; k++) begin
            if (ir_value == IR_WIDTH'(OP_USER_BASE + k)) begin
                user_onehot[k] = 1'b1;
                user_capture   = dr_capture_data[k*DR_WIDTH +: DR_WIDTH];
            end
        end
        sel_user = |user_onehot;
    end

    // TDI enters at the top of the selected register length; unused upper bits are don't-care.
    always_comb begin
        dr_sr_next = dr_sr;
        case (state)
            DR_CAPTURE: begin
                if (sel_user)        dr_sr_next = SR_WIDTH'(user_capture);
                else if (sel_idcode) dr_sr_next = SR_WIDTH'(IDCODE_VAL);
                else                 dr_sr_next = '0;
            end
            DR_SHIFT: begin
                dr_sr_next = dr_sr >> 1;
                if (sel_user)        dr_sr_next[DR_WIDTH-1]   = TDI;
                else if (sel_idcode) dr_sr_next[IDCODE_MSB]   = TDI;
                else                 dr_sr_next[0]            = TDI;
            end
            default: ;
        endcase
    end

    always_comb begin
        TDO = 1'b0;
        if (state == DR_SHIFT)      TDO = dr_sr[0];
        else if (state == IR_SHIFT) TDO = ir_sr[0];
    end

    always_ff @(posedge TCLK) begin
        dr_sr <= dr_sr_next;
        case (state)
            IR_CAPTURE: ir_sr <= IR_WIDTH'(1);
            IR_SHIFT:   ir_sr <= {TDI, ir_sr[IR_WIDTH-1:1]};
            default: ;
        endcase
    end

    always_ff @(posedge TCLK) begin
        if (TRST) begin
            ir_reg          <= IR_RESET;
            dr_update_data  <= '0;
            dr_update_valid <= '0;
        end else begin
            dr_update_valid <= '0;
            if (state == TEST_RESET)     ir_reg <= IR_RESET;
            else if (state == IR_UPDATE) ir_reg <= ir_sr;
            if ((state == DR_UPDATE) && sel_user) begin
                dr_update_data  <= dr_sr[DR_WIDTH-1:0];
                dr_update_valid <= user_onehot;
            end
        end
    end

endmodule

// File: tb/tb_jtag_tap_multi_dr.sv
// Bench for jtag_tap_multi_dr: queue-based TAP model checked every cycle, plus literal scan scenarios.
module tb_jtag_tap_multi_dr;
    import jtag_pkg::*;

    localparam int IR_W   = 4;
    localparam int DR_W   = 32;
    localparam int NUM_DR = 2;
`ifdef JTAG_TAP_IDCODE_EN
    localparam logic [IR_W-1:0] RST_IR = 4'h1;
`else
    localparam logic [IR_W-1:0] RST_IR = 4'hF;
`endif

    logic                     TCLK = 1'b0;
    logic                     TRST = 1'b1;
    logic                     TMS  = 1'b1;
    logic                     TDI  = 1'b0;
    logic                     TDO;
    logic                     TDO_EN;
    logic [IR_W-1:0]          ir_value;
    logic [NUM_DR*DR_W-1:0]   dr_capture_data = '0;
    logic [DR_W-1:0]          dr_update_data;
    logic [NUM_DR-1:0]        dr_update_valid;
    logic [3:0]               tap_state;

    int  checks = 0;
    int  errors = 0;
    bit  cmp_en = 1'b0;
    bit  cap_random = 1'b0;
    logic [31:0] idcode_v = 32'h1000_0001;

    jtag_tap_multi_dr #(
        .IR_WIDTH    (IR_W),
        .DR_WIDTH    (DR_W),
        .NUM_USER_DR (NUM_DR),
        .IDCODE_VAL  (32'h1000_0001)
    ) dut (
        .TCLK            (TCLK),
        .TRST            (TRST),
        .TMS             (TMS),
        .TDI             (TDI),
        .TDO             (TDO),
        .TDO_EN          (TDO_EN),
        .ir_value        (ir_value),
        .dr_capture_data (dr_capture_data),
        .dr_update_data  (dr_update_data),
        .dr_update_valid (dr_update_valid),
        .tap_state       (tap_state)
    );

    always #5 TCLK = ~TCLK;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Model: standard TAP graph, registers held as bit queues with index 0 facing TDO.
    tap_state_t        m_state = TEST_RESET;
    logic [IR_W-1:0]   m_ir = RST_IR;
    logic [DR_W-1:0]   m_upd_data = '0;
    logic [NUM_DR-1:0] m_upd_valid = '0;
    bit                m_dr[$];
    bit                m_irq[$];

    function automatic tap_state_t tap_next(tap_state_t s, logic tms);
        case (s)
            TEST_RESET: return tms ? TEST_RESET : TEST_IDLE;
            TEST_IDLE:  return tms ? DR_SELECT  : TEST_IDLE;
            DR_SELECT:  return tms ? IR_SELECT  : DR_CAPTURE;
            IR_SELECT:  return tms ? TEST_RESET : IR_CAPTURE;
            DR_CAPTURE, DR_SHIFT, DR_EXIT2: return tms ? (s == DR_EXIT2 ? DR_UPDATE : DR_EXIT1) : DR_SHIFT;
            IR_CAPTURE, IR_SHIFT, IR_EXIT2: return tms ? (s == IR_EXIT2 ? IR_UPDATE : IR_EXIT1) : IR_SHIFT;
            DR_EXIT1, DR_PAUSE: return tms ? (s == DR_EXIT1 ? DR_UPDATE : DR_EXIT2) : DR_PAUSE;
            IR_EXIT1, IR_PAUSE: return tms ? (s == IR_EXIT1 ? IR_UPDATE : IR_EXIT2) : IR_PAUSE;
            DR_UPDATE, IR_UPDATE: return tms ? DR_SELECT : TEST_IDLE;
            default: return TEST_RESET;
        endcase
    endfunction

    // -2 bypass, -1 idcode, k >= 0 user register k.
    function automatic int selected(logic [IR_W-1:0] op);
        int v;
        v = int'(op);
        if (v >= 2 && v < 2 + NUM_DR) return v - 2;
`ifdef JTAG_TAP_IDCODE_EN
        if (v == 1) return -1;
`endif
        return -2;
    endfunction

    always @(posedge TCLK) begin : model
        int k;
        if (TRST) begin
            m_state     = TEST_RESET;
            m_ir        = RST_IR;
            m_upd_data  = '0;
            m_upd_valid = '0;
        end else begin
            m_upd_valid = '0;
            k = selected(m_ir);
            case (m_state)
                TEST_RESET: m_ir = RST_IR;
                DR_CAPTURE: begin
                    m_dr.delete();
                    if (k >= 0)       for (int i = 0; i < DR_W; i++) m_dr.push_back(dr_capture_data[k*DR_W + i]);
                    else if (k == -1) for (int i = 0; i < 32; i++) m_dr.push_back(idcode_v[i]);
                    else              m_dr.push_back(1'b0);
                end
                DR_SHIFT: begin
                    void'(m_dr.pop_front());
                    m_dr.push_back(TDI);
                end
                IR_CAPTURE: begin
                    m_irq.delete();
                    m_irq.push_back(1'b1);
                    for (int i = 1; i < IR_W; i++) m_irq.push_back(1'b0);
                end
                IR_SHIFT: begin
                    void'(m_irq.pop_front());
                    m_irq.push_back(TDI);
                end
                DR_UPDATE: if (k >= 0) begin
                    for (int i = 0; i < DR_W; i++) m_upd_data[i] = m_dr[i];
                    m_upd_valid = NUM_DR'(1) << k;
                end
                IR_UPDATE: for (int i = 0; i < IR_W; i++) m_ir[i] = m_irq[i];
                default: ;
            endcase
            m_state = tap_next(m_state, TMS);
        end
    end

    always @(negedge TCLK) begin
        if (cmp_en) begin
            logic exp_tdo;
            exp_tdo = 1'b0;
            if (m_state == DR_SHIFT)      exp_tdo = m_dr[0];
            else if (m_state == IR_SHIFT) exp_tdo = m_irq[0];
            checkOutput("tap_state", 64'(tap_state), 64'(m_state));
            checkOutput("tdo_en", 64'(TDO_EN), 64'((m_state == DR_SHIFT) || (m_state == IR_SHIFT)));
            checkOutput("tdo", 64'(TDO), 64'(exp_tdo));
            checkOutput("ir_value", 64'(ir_value), 64'((m_state == TEST_RESET) ? RST_IR : m_ir));
            checkOutput("upd_data", 64'(dr_update_data), 64'(m_upd_data));
            checkOutput("upd_valid", 64'(dr_update_valid), 64'(m_upd_valid));
        end
    end

    // Drives one cycle of pins at the negedge and returns TDO as seen during that cycle.
    task automatic applyStimulus(input logic tms, input logic tdi, output logic tdo);
        @(negedge TCLK);
        TMS = tms;
        TDI = tdi;
        if (cap_random) dr_capture_data = {$urandom, $urandom};
        tdo = TDO;
    endtask

    task automatic goto_idle();
        logic t;
        repeat (5) applyStimulus(1'b1, 1'b0, t);
        applyStimulus(1'b0, 1'b0, t);
    endtask

    task automatic scan_ir(input logic [IR_W-1:0] op, output logic [IR_W-1:0] tdo_bits);
        logic t;
        tdo_bits = '0;
        applyStimulus(1'b1, 1'b0, t);
        applyStimulus(1'b1, 1'b0, t);
        applyStimulus(1'b0, 1'b0, t);
        applyStimulus(1'b0, 1'b0, t);
        for (int i = 0; i < IR_W; i++) begin
            applyStimulus(i == IR_W - 1, op[i], t);
            tdo_bits[i] = t;
        end
        applyStimulus(1'b1, 1'b0, t);
        applyStimulus(1'b0, 1'b0, t);
    endtask

    task automatic scan_dr(input logic [63:0] data, input int n, input int pause_at, output logic [63:0] tdo_bits);
        logic t;
        tdo_bits = '0;
        applyStimulus(1'b1, 1'b0, t);
        applyStimulus(1'b0, 1'b0, t);
        applyStimulus(1'b0, 1'b0, t);
        for (int i = 0; i < n; i++) begin
            applyStimulus((i == n - 1) || (i == pause_at - 1), data[i], t);
            tdo_bits[i] = t;
            if ((i == pause_at - 1) && (i != n - 1)) begin
                repeat (3) applyStimulus(1'b0, 1'b0, t);
                applyStimulus(1'b1, 1'b0, t);
                applyStimulus(1'b0, 1'b0, t);
            end
        end
        applyStimulus(1'b1, 1'b0, t);
        applyStimulus(1'b0, 1'b0, t);
    endtask

    initial begin
        logic [63:0]     tb;
        logic [IR_W-1:0] ib;
        logic            t;
        int              n;

        @(posedge TCLK);
        @(negedge TCLK);
        cmp_en = 1'b1;
        checkOutput("rst_state", 64'(tap_state), 64'd0);
        checkOutput("rst_ir", 64'(ir_value), 64'(RST_IR));
        checkOutput("rst_tdo", 64'({TDO_EN, TDO}), 64'd0);
        checkOutput("rst_upd", 64'({dr_update_valid, dr_update_data}), 64'd0);
        TRST = 1'b0;

        goto_idle();
        scan_dr(64'hA5A5_F00F, 32, 0, tb);
`ifdef JTAG_TAP_IDCODE_EN
        checkOutput("idcode_stream", 64'(tb[31:0]), 64'h1000_0001);
`else
        checkOutput("idcode_bypass_stream", 64'(tb[31:0]), 64'h4B4B_E01E);
`endif
        @(negedge TCLK);
        checkOutput("idcode_no_strobe", 64'(dr_update_valid), 64'd0);

        scan_ir(4'hF, ib);
        checkOutput("ir_capture", 64'(ib), 64'h1);
        @(negedge TCLK);
        checkOutput("ir_bypass", 64'(ir_value), 64'hF);
        scan_dr(64'hD, 4, 0, tb);
        checkOutput("bypass_stream", 64'(tb[3:0]), 64'hA);
        @(negedge TCLK);
        checkOutput("bypass_no_strobe", 64'(dr_update_valid), 64'd0);

        dr_capture_data = {32'h0BAD_F00D, 32'hDEAD_BEEF};
        scan_ir(4'h2, ib);
        scan_dr(64'h1234_5678, 32, 0, tb);
        checkOutput("user0_stream", 64'(tb[31:0]), 64'hDEAD_BEEF);
        @(negedge TCLK);
        checkOutput("user0_data", 64'(dr_update_data), 64'h1234_5678);
        checkOutput("user0_valid", 64'(dr_update_valid), 64'h1);
        @(negedge TCLK);
        checkOutput("user0_valid_once", 64'(dr_update_valid), 64'h0);

        dr_capture_data = {32'hCAFE_F00D, 32'h1111_2222};
        scan_ir(4'h3, ib);
        scan_dr(64'h89AB_CDEF, 32, 16, tb);
        checkOutput("pause_stream", 64'(tb[31:0]), 64'hCAFE_F00D);
        @(negedge TCLK);
        checkOutput("pause_data", 64'(dr_update_data), 64'h89AB_CDEF);
        checkOutput("pause_valid", 64'(dr_update_valid), 64'h2);

        // TRST in the middle of a user DR shift.
        scan_ir(4'h2, ib);
        applyStimulus(1'b1, 1'b0, t);
        applyStimulus(1'b0, 1'b0, t);
        applyStimulus(1'b0, 1'b0, t);
        repeat (10) applyStimulus(1'b0, 1'($urandom_range(0, 1)), t);
        @(negedge TCLK);
        TRST = 1'b1;
        @(negedge TCLK);
        checkOutput("trst_state", 64'(tap_state), 64'd0);
        checkOutput("trst_ir", 64'(ir_value), 64'(RST_IR));
        checkOutput("trst_upd", 64'({dr_update_valid, dr_update_data}), 64'd0);
        TRST = 1'b0;

        // Five TMS=1 edges from IR_SHIFT.
        goto_idle();
        scan_ir(4'h3, ib);
        applyStimulus(1'b1, 1'b0, t);
        applyStimulus(1'b1, 1'b0, t);
        applyStimulus(1'b0, 1'b0, t);
        applyStimulus(1'b0, 1'b0, t);
        repeat (2) applyStimulus(1'b0, 1'b1, t);
        repeat (5) applyStimulus(1'b1, 1'b0, t);
        @(negedge TCLK);
        checkOutput("tms5_state", 64'(tap_state), 64'd0);
        checkOutput("tms5_ir", 64'(ir_value), 64'(RST_IR));
        checkOutput("tms5_valid", 64'(dr_update_valid), 64'd0);

        cap_random = 1'b1;
        repeat (80) begin
            case ($urandom_range(0, 4))
                0: repeat ($urandom_range(1, 20))
                       applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), t);
                1: begin
                    goto_idle();
                    scan_ir(IR_W'($urandom_range(0, 15)), ib);
                end
                2, 3: begin
                    goto_idle();
                    scan_ir(IR_W'($urandom_range(0, 4)), ib);
                    n = $urandom_range(1, 40);
                    scan_dr({$urandom, $urandom}, n, int'($urandom_range(0, 39)) % n, tb);
                end
                default: begin
                    @(negedge TCLK);
                    TRST = 1'b1;
                    @(negedge TCLK);
                    TRST = 1'b0;
                end
            endcase
        end

        repeat (2) @(negedge TCLK);
        cmp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
